// File: rtl/integral_mem_arbiter.sv
// Read-port arbiter, write register and read-during-write forwarding
// for the integral-image M10K.
module integral_mem_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_rd_req,
  input  logic [ADDR_W-1:0] a_rd_addr,
  output logic              a_rd_gnt,
  output logic              a_rd_valid,
  output logic [DATA_W-1:0] a_rd_data,
  input  logic              a_wr_en,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic              b_rd_req,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic              b_rd_gnt,
  output logic              b_rd_valid,
  output logic [DATA_W-1:0] b_rd_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_acc;
  logic              w_fwd;
  logic [ADDR_W-1:0] w_addr;

  logic              r_last_b;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_s1_vld;
  logic              r_s1_tag;
  logic              r_s1_fwd;
  logic              r_s2_vld;
  logic              r_s2_tag;
  logic              r_s2_fwd;
  logic [DATA_W-1:0] r_s2_fdata;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_a_vld;
  logic              r_b_vld;
  logic [DATA_W-1:0] r_a_data;
  logic [DATA_W-1:0] r_b_data;

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (a_rd_req && b_rd_req) begin
      if (ARB_MODE == 1 || r_last_b)
        w_a_gnt = 1'b1;
      else
        w_b_gnt = 1'b1;
    end else begin
      w_a_gnt = a_rd_req;
      w_b_gnt = b_rd_req;
    end
  end

  assign w_acc  = w_a_gnt | w_b_gnt;
  assign w_addr = w_a_gnt ? a_rd_addr : b_rd_addr;
  // same-cycle write would be missed by the old-data M10K read
  assign w_fwd  = w_acc && a_wr_en && (a_wr_addr == w_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_b   <= 1'b1;
      r_rd_addr  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_tag   <= 1'b0;
      r_s1_fwd   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_tag   <= 1'b0;
      r_s2_fwd   <= 1'b0;
      r_s2_fdata <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_a_vld    <= 1'b0;
      r_b_vld    <= 1'b0;
      r_a_data   <= '0;
      r_b_data   <= '0;
    end else begin
      if (w_acc) begin
        r_last_b  <= w_b_gnt;
        r_rd_addr <= w_addr;
      end
      r_s1_vld   <= w_acc;
      r_s1_tag   <= w_b_gnt;
      r_s1_fwd   <= w_fwd;
      r_wr_en    <= a_wr_en;
      r_wr_addr  <= a_wr_addr;
      r_wr_data  <= a_wr_data;
      r_s2_vld   <= r_s1_vld;
      r_s2_tag   <= r_s1_tag;
      r_s2_fwd   <= r_s1_fwd;
      r_s2_fdata <= r_wr_data;
      r_a_vld    <= r_s2_vld && !r_s2_tag;
      r_b_vld    <= r_s2_vld && r_s2_tag;
      if (r_s2_vld && !r_s2_tag)
        r_a_data <= r_s2_fwd ? r_s2_fdata : mem_rd_data;
      if (r_s2_vld && r_s2_tag)
        r_b_data <= r_s2_fwd ? r_s2_fdata : mem_rd_data;
    end
  end

  assign a_rd_gnt    = w_a_gnt;
  assign b_rd_gnt    = w_b_gnt;
  assign a_rd_valid  = r_a_vld;
  assign b_rd_valid  = r_b_vld;
  assign a_rd_data   = r_a_data;
  assign b_rd_data   = r_b_data;
  assign mem_rd_addr = r_rd_addr;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;

endmodule

// File: tb/tb_integral_mem_arbiter.sv
// Bench for integral_mem_arbiter: round-robin and fixed-priority
// instances share stimulus; each drives its own M10K model.
module tb_integral_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_clr;
  logic       a_rd_req, b_rd_req, a_wr_en;
  logic [7:0] a_rd_addr, b_rd_addr, a_wr_addr, a_wr_data;

  logic [1:0] a_gnt, b_gnt, a_vld, b_vld, m_wen;
  logic [7:0] a_dat [2];
  logic [7:0] b_dat [2];
  logic [7:0] m_raddr [2];
  logic [7:0] m_rdata [2];
  logic [7:0] m_waddr [2];
  logic [7:0] m_wdata [2];

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  integral_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(rst_n),
    .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_gnt[0]),
    .a_rd_valid(a_vld[0]), .a_rd_data(a_dat[0]),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_gnt[0]),
    .b_rd_valid(b_vld[0]), .b_rd_data(b_dat[0]),
    .mem_rd_addr(m_raddr[0]), .mem_rd_data(m_rdata[0]),
    .mem_wr_en(m_wen[0]), .mem_wr_addr(m_waddr[0]),
    .mem_wr_data(m_wdata[0])
  );

  integral_mem_arbiter #(.DATA_W(8), .ADDR_W(8), .ARB_MODE(1)) u_fp (
    .clk(clk), .reset(rst_n),
    .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_gnt[1]),
    .a_rd_valid(a_vld[1]), .a_rd_data(a_dat[1]),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_gnt[1]),
    .b_rd_valid(b_vld[1]), .b_rd_data(b_dat[1]),
    .mem_rd_addr(m_raddr[1]), .mem_rd_data(m_rdata[1]),
    .mem_wr_en(m_wen[1]), .mem_wr_addr(m_waddr[1]),
    .mem_wr_data(m_wdata[1])
  );

  // M10K: registered read, old data on read-during-write
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 8'h00;
        mem1[i] <= 8'h00;
      end
      m_rdata[0] <= 8'h00;
      m_rdata[1] <= 8'h00;
    end else begin
      m_rdata[0] <= mem0[m_raddr[0]];
      m_rdata[1] <= mem1[m_raddr[1]];
      if (m_wen[0]) mem0[m_waddr[0]] <= m_wdata[0];
      if (m_wen[1]) mem1[m_waddr[1]] <= m_wdata[1];
    end
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d: got %0h, want %0h",
               nm, k, cyc, act, exp);
    end
  endtask

  // Reference model: contents as seen by a read, reads due 3 cycles on
  logic [7:0] shadow [256];
  logic       hv   [2][4];
  logic       htag [2][4];
  logic [7:0] hd   [2][4];
  logic       last_b [2];
  logic [7:0] exp_a [2];
  logic [7:0] exp_b [2];
  logic [7:0] exp_ra [2];
  logic       p_wen;
  logic [7:0] p_waddr, p_wdata;

  always @(negedge clk) begin
    int due, now;
    logic ga, gb;
    logic [7:0] ad;
    if (mem_clr)
      for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_a_valid", k, a_vld[k], 0);
        chk("rst_b_valid", k, b_vld[k], 0);
        chk("rst_a_data", k, a_dat[k], 0);
        chk("rst_b_data", k, b_dat[k], 0);
        chk("rst_rd_addr", k, m_raddr[k], 0);
        chk("rst_wr_en", k, m_wen[k], 0);
        chk("rst_wr_addr", k, m_waddr[k], 0);
        chk("rst_wr_data", k, m_wdata[k], 0);
        for (int s = 0; s < 4; s++) hv[k][s] = 1'b0;
        last_b[k] = 1'b1;
        exp_a[k] = 8'h00;
        exp_b[k] = 8'h00;
        exp_ra[k] = 8'h00;
      end
      p_wen = 1'b0;
      p_waddr = 8'h00;
      p_wdata = 8'h00;
    end else begin
      due = (cyc + 1) % 4;
      now = cyc % 4;
      for (int k = 0; k < 2; k++) begin
        ga = a_rd_req && (!b_rd_req || k == 1 || last_b[k]);
        gb = b_rd_req && !ga;
        chk("a_gnt", k, a_gnt[k], ga);
        chk("b_gnt", k, b_gnt[k], gb);
        chk("a_valid", k, a_vld[k], hv[k][due] && !htag[k][due]);
        chk("b_valid", k, b_vld[k], hv[k][due] && htag[k][due]);
        if (hv[k][due] && !htag[k][due]) exp_a[k] = hd[k][due];
        if (hv[k][due] && htag[k][due]) exp_b[k] = hd[k][due];
        chk("a_data", k, a_dat[k], exp_a[k]);
        chk("b_data", k, b_dat[k], exp_b[k]);
        chk("mem_rd_addr", k, m_raddr[k], exp_ra[k]);
        chk("mem_wr_en", k, m_wen[k], p_wen);
        if (p_wen) begin
          chk("mem_wr_addr", k, m_waddr[k], p_waddr);
          chk("mem_wr_data", k, m_wdata[k], p_wdata);
        end
        ad = ga ? a_rd_addr : b_rd_addr;
        hv[k][now] = ga | gb;
        htag[k][now] = gb;
        hd[k][now] = (a_wr_en && a_wr_addr == ad) ? a_wr_data : shadow[ad];
        if (ga | gb) begin
          last_b[k] = gb;
          exp_ra[k] = ad;
        end
      end
      if (a_wr_en) shadow[a_wr_addr] = a_wr_data;
      p_wen = a_wr_en;
      p_waddr = a_wr_addr;
      p_wdata = a_wr_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [7:0] ad,
                    input logic [7:0] d);
    a_wr_en = en;
    a_wr_addr = ad;
    a_wr_data = d;
  endtask

  initial begin
    logic hold_a, hold_b;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    a_rd_req = 1'b0; b_rd_req = 1'b0;
    a_rd_addr = 8'h00; b_rd_addr = 8'h00;
    wr(1'b0, 8'h00, 8'h00);
    tick; tick;
    mem_clr = 1'b0;
    rst_n = 1'b1;
    tick;

    // write path: three back-to-back writes, one cycle later on mem_wr_*
    wr(1'b1, 8'd1, 8'h01);
    tick;
    wr(1'b1, 8'd2, 8'h02);
    @(negedge clk);
    chk("lit_wr1", 0, {m_wen[0], m_waddr[0], m_wdata[0]}, {1'b1, 8'd1, 8'h01});
    tick;
    wr(1'b1, 8'd3, 8'h03);
    @(negedge clk);
    chk("lit_wr2", 0, {m_wen[0], m_waddr[0], m_wdata[0]}, {1'b1, 8'd2, 8'h02});
    tick;
    wr(1'b0, 8'd0, 8'h00);
    @(negedge clk);
    chk("lit_wr3", 0, {m_wen[0], m_waddr[0], m_wdata[0]}, {1'b1, 8'd3, 8'h03});
    tick;
    @(negedge clk);
    chk("lit_wr_end", 0, m_wen[0], 0);

    // preload mem[5]=2A, mem[7]=10
    tick;
    wr(1'b1, 8'd5, 8'h2A);
    tick;
    wr(1'b1, 8'd7, 8'h10);
    tick;
    wr(1'b0, 8'd0, 8'h00);
    tick; tick;

    // single A read of addr 5
    a_rd_req = 1'b1; a_rd_addr = 8'd5;
    @(negedge clk);
    chk("lit_single_gnt", 0, {a_gnt[0], b_gnt[0]}, 2'b10);
    tick;
    a_rd_req = 1'b0;
    tick;
    @(negedge clk);
    chk("lit_single_early", 0, a_vld[0], 0);
    tick;
    @(negedge clk);
    chk("lit_single_vld", 0, {a_vld[0], b_vld[0]}, 2'b10);
    chk("lit_single_data", 0, a_dat[0], 8'h2A);
    tick;
    @(negedge clk);
    chk("lit_single_pulse", 0, a_vld[0], 0);

    // forwarding: write 7=55 and B read 7 in the same cycle
    wr(1'b1, 8'd7, 8'h55);
    b_rd_req = 1'b1; b_rd_addr = 8'd7;
    tick;
    wr(1'b0, 8'd0, 8'h00);
    b_rd_req = 1'b0;
    tick;
    b_rd_req = 1'b1;
    tick;
    b_rd_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("lit_fwd_vld", k, b_vld[k], 1);
      chk("lit_fwd_data", k, b_dat[k], 8'h55);
    end
    tick; tick;
    @(negedge clk);
    chk("lit_mem_vld", 0, b_vld[0], 1);
    chk("lit_mem_data", 0, b_dat[0], 8'h55);

    // reset one cycle after an accepted A read
    tick;
    a_rd_req = 1'b1; a_rd_addr = 8'd9;
    tick;
    a_rd_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_rd_addr", 0, m_raddr[0], 0);
    tick;
    rst_n = 1'b1;

    // contention straight after reset
    a_rd_req = 1'b1; a_rd_addr = 8'd3;
    b_rd_req = 1'b1; b_rd_addr = 8'd4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lit_rr_a", 0, a_gnt[0], (i % 2) == 0);
      chk("lit_rr_b", 0, b_gnt[0], (i % 2) == 1);
      chk("lit_fp_a", 1, {a_gnt[1], b_gnt[1]}, 2'b10);
      tick;
    end
    a_rd_req = 1'b0;
    @(negedge clk);
    chk("lit_fp_b", 1, b_gnt[1], 1);
    tick;
    b_rd_req = 1'b0;
    repeat (4) tick;

    // randomized traffic, losers hold req/addr until granted
    hold_a = 1'b0;
    hold_b = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold_a) begin
        a_rd_req = ($urandom_range(0, 2) != 0);
        a_rd_addr = 8'($urandom_range(0, 15));
      end
      if (!hold_b) begin
        b_rd_req = ($urandom_range(0, 2) != 0);
        b_rd_addr = 8'($urandom_range(0, 15));
      end
      wr($urandom_range(0, 2) == 0, 8'($urandom_range(0, 15)),
         8'($urandom));
      @(negedge clk);
      hold_a = a_rd_req && !a_gnt[0];
      hold_b = b_rd_req && !b_gnt[0];
      tick;
    end
    a_rd_req = 1'b0;
    b_rd_req = 1'b0;
    wr(1'b0, 8'd0, 8'h00);
    repeat (6) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
